alu_control_seq: RTL

- Parametrised, registered ALU control unit for the MIPS datapath. Decodes op/funct into an ALU control code.
- Also sequences multi-cycle multiply/divide operations through a counter-based FSM with a pipeline stall and a HI/LO write strobe.
- Latches the break instruction into a sticky halt.
- Sits between the main decoder and the ALU/MDU in the execute stage.

---
 rtl/alu_ctrl_pkg.sv | 55 +++++
 rtl/alu_ctrl_decode.sv | 62 ++++++
 rtl/alu_control_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes, MIPS opcode/funct constants and sequencer state encoding
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_ADDU  = 4'b0100;
    localparam logic [3:0] ALU_SUBU  = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_DIV   = 4'b1011;
    localparam logic [3:0] ALU_DIVU  = 4'b1100;
    localparam logic [3:0] ALU_PASS  = 4'b1101;
    localparam logic [3:0] ALU_NOP   = 4'b1110;
    localparam logic [3:0] ALU_BREAK = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_BREAK = 6'b001101;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MDU_RUN = 2'd1,
        S_HALTED  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational op/funct to ALU control code with MDU/break classification
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int CTRL_W  = 4
) (
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  code,
    output logic               illegal,
    output logic               is_mult,
    output logic               is_div,
    output logic               is_break
);

    logic [3:0] code4;

    // table lookup; anything unlisted falls back to NOP and flags illegal
    always_comb begin
        code4   = ALU_NOP;
        illegal = 1'b0;
        case (op)
            OP_W'(OP_RTYPE): begin
                case (funct)
                    FUNCT_W'(F_ADD):   code4 = ALU_ADD;
                    FUNCT_W'(F_ADDU):  code4 = ALU_ADDU;
                    FUNCT_W'(F_SUB):   code4 = ALU_SUB;
                    FUNCT_W'(F_SUBU):  code4 = ALU_SUBU;
                    FUNCT_W'(F_AND):   code4 = ALU_AND;
                    FUNCT_W'(F_OR):    code4 = ALU_OR;
                    FUNCT_W'(F_XOR):   code4 = ALU_XOR;
                    FUNCT_W'(F_SLT):   code4 = ALU_SLT;
                    FUNCT_W'(F_SLTU):  code4 = ALU_SLTU;
                    FUNCT_W'(F_MULT):  code4 = ALU_MULT;
                    FUNCT_W'(F_MULTU): code4 = ALU_MULTU;
                    FUNCT_W'(F_DIV):   code4 = ALU_DIV;
                    FUNCT_W'(F_DIVU):  code4 = ALU_DIVU;
                    FUNCT_W'(F_JR):    code4 = ALU_PASS;
                    FUNCT_W'(F_BREAK): code4 = ALU_BREAK;
                    default:           illegal = 1'b1;
                endcase
            end
            OP_W'(OP_LW), OP_W'(OP_SW):  code4 = ALU_ADD;
            OP_W'(OP_BEQ), OP_W'(OP_BNE): code4 = ALU_SUB;
            OP_W'(OP_ANDI):  code4 = ALU_AND;
            OP_W'(OP_ORI):   code4 = ALU_OR;
            OP_W'(OP_XORI):  code4 = ALU_XOR;
            OP_W'(OP_ADDIU): code4 = ALU_ADDU;
            OP_W'(OP_SLTI):  code4 = ALU_SLT;
            OP_W'(OP_SLTIU): code4 = ALU_SLTU;
            default:         illegal = 1'b1;
        endcase
    end

    assign code     = CTRL_W'(code4);
    assign is_mult  = (code4 == ALU_MULT) || (code4 == ALU_MULTU);
    assign is_div   = (code4 == ALU_DIV) || (code4 == ALU_DIVU);
    assign is_break = (code4 == ALU_BREAK);

endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered ALU control decode with multiply/divide latency sequencing and break halt
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int FUNCT_W  = 6,
    parameter int CTRL_W   = 4,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_valid,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               flush,
    output logic [CTRL_W-1:0]  control,
    output logic               ctrl_valid,
    output logic               illegal,
    output logic               mdu_busy,
    output logic               stall,
    output logic               hilo_we,
    output logic               halt
);

    logic [CTRL_W-1:0] dec_code;
    logic              dec_illegal;
    logic              dec_mult;
    logic              dec_div;
    logic              dec_break;
    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CTRL_W-1:0] control_q;
    logic              ctrl_valid_q;
    logic              illegal_q;
    logic              mdu_done;
    logic              accept;

    alu_ctrl_decode #(
        .OP_W    (OP_W),
        .FUNCT_W (FUNCT_W),
        .CTRL_W  (CTRL_W)
    ) u_decode (
        .op       (op),
        .funct    (funct),
        .code     (dec_code),
        .illegal  (dec_illegal),
        .is_mult  (dec_mult),
        .is_div   (dec_div),
        .is_break (dec_break)
    );

    // the MDU frees on its last busy cycle, so a held instruction is taken on that same edge
    assign mdu_done = (state_q == S_MDU_RUN) && (cnt_q == '0);
    assign accept   = issue_valid && !flush && ((state_q == S_IDLE) || mdu_done);

    // state register and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state: count down an MDU run, abort on flush, launch on an accepted mult/div/break
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_MDU_RUN) begin
            state_d = (flush || mdu_done) ? S_IDLE : S_MDU_RUN;
            cnt_d   = (flush || mdu_done) ? '0 : cnt_q - CNT_W'(1);
        end
        if (accept && dec_mult) begin
            state_d = S_MDU_RUN;
            cnt_d   = CNT_W'(MULT_LAT - 1);
        end else if (accept && dec_div) begin
            state_d = S_MDU_RUN;
            cnt_d   = CNT_W'(DIV_LAT - 1);
        end else if (accept && dec_break) begin
            state_d = S_HALTED;
        end
    end

    // state-derived outputs; a flush on the final cycle kills the HI/LO write
    always_comb begin
        mdu_busy = (state_q == S_MDU_RUN);
        halt     = (state_q == S_HALTED);
        stall    = mdu_busy || halt;
        hilo_we  = mdu_done && !flush;
    end

    // decoded control is captured only on accept and held until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            control_q    <= '0;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            control_q    <= accept ? dec_code : control_q;
            ctrl_valid_q <= accept;
            illegal_q    <= accept && dec_illegal;
        end
    end

    assign control    = control_q;
    assign ctrl_valid = ctrl_valid_q;
    assign illegal    = illegal_q;

endmodule
